// File: rtl/inner_dot_mac_pipe.sv
// Pipelined signed dot-product MAC: TAPS products per beat, registered adder tree,
// per-group accumulation and a rounded/shifted/saturated (optional ReLU) output.
module inner_dot_mac_pipe #(
  parameter int TAPS   = 9,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CH_W   = 8,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CH_W-1:0]          cfg_ch_num,
  input  logic [4:0]               cfg_shift,
  input  logic                     cfg_relu,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAPS*DATA_W-1:0]   in_data,
  input  logic [TAPS*DATA_W-1:0]   in_weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [ACC_W-1:0]         out_acc
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

  logic en;
  logic accept;

  // group control
  logic [CH_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] ch_num_q, ch_num_d;
  logic [4:0]      shift_q, shift_d;
  logic            relu_q, relu_d;
  logic [CH_W-1:0] cfg_ch_eff;
  logic [CH_W-1:0] beat_ch;
  logic            beat_first, beat_last;
  logic [4:0]      beat_shift;
  logic            beat_relu;

  // stage 1
  logic signed [PROD_W-1:0] mul [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic       s1_valid_q, s1_valid_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic [4:0] s1_shift_q, s1_shift_d;
  logic       s1_relu_q, s1_relu_d;

  // stage 2
  logic signed [ACC_W-1:0] tree_sum;
  logic signed [ACC_W-1:0] sum_q, sum_d;
  logic       s2_valid_q, s2_valid_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
  logic [4:0] s2_shift_q, s2_shift_d;
  logic       s2_relu_q, s2_relu_d;

  // stage 3
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_new;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic [ACC_W-1:0]        out_acc_q, out_acc_d;
  logic signed [ACC_W:0]   acc_ext, rnd, shifted, sat;

  assign en       = !(out_valid_q && !out_ready);
  assign in_ready = en && !rst;
  assign accept   = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_mul
      logic signed [PROD_W-1:0] a_ext, b_ext;
      assign a_ext   = PROD_W'($signed(in_data[gi*DATA_W +: DATA_W]));
      assign b_ext   = PROD_W'($signed(in_weight[gi*DATA_W +: DATA_W]));
      assign mul[gi] = a_ext * b_ext;
    end
  endgenerate

  // The first beat of a group takes config straight from the ports; later beats use the latched copy.
  always_comb begin
    cfg_ch_eff = (cfg_ch_num == '0) ? CH_W'(1) : cfg_ch_num;
    beat_first = (cnt_q == '0);
    beat_ch    = beat_first ? cfg_ch_eff : ch_num_q;
    beat_shift = beat_first ? cfg_shift : shift_q;
    beat_relu  = beat_first ? cfg_relu : relu_q;
    beat_last  = (cnt_q == beat_ch - CH_W'(1));

    cnt_d    = cnt_q;
    ch_num_d = ch_num_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    if (accept) begin
      cnt_d = beat_last ? '0 : cnt_q + CH_W'(1);
      if (beat_first) begin
        ch_num_d = cfg_ch_eff;
        shift_d  = cfg_shift;
        relu_d   = cfg_relu;
      end
    end
  end

  always_comb begin
    prod_d     = prod_q;
    s1_valid_d = s1_valid_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_shift_d = s1_shift_q;
    s1_relu_d  = s1_relu_q;
    if (en) begin
      prod_d     = mul;
      s1_valid_d = accept;
      s1_first_d = beat_first;
      s1_last_d  = beat_last;
      s1_shift_d = beat_shift;
      s1_relu_d  = beat_relu;
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < TAPS; i++) begin
      tree_sum = tree_sum + ACC_W'(prod_q[i]);
    end
    sum_d      = sum_q;
    s2_valid_d = s2_valid_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
    s2_shift_d = s2_shift_q;
    s2_relu_d  = s2_relu_q;
    if (en) begin
      sum_d      = tree_sum;
      s2_valid_d = s1_valid_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_shift_d = s1_shift_q;
      s2_relu_d  = s1_relu_q;
    end
  end

  // Requant runs one bit wider than the accumulator so the rounding add cannot overflow.
  always_comb begin
    acc_new = s2_first_q ? sum_q : acc_q + sum_q;
    acc_ext = (ACC_W+1)'(acc_new);
    rnd     = (s2_shift_q != 5'd0) ? ((ACC_W+1)'(1) <<< (s2_shift_q - 5'd1)) : '0;
    shifted = (acc_ext + rnd) >>> s2_shift_q;
    if (shifted > OUT_MAX) begin
      sat = OUT_MAX;
    end else if (shifted < OUT_MIN) begin
      sat = OUT_MIN;
    end else begin
      sat = shifted;
    end
    if (s2_relu_q && sat < 0) begin
      sat = '0;
    end

    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_acc_d   = out_acc_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (en && s2_valid_q) begin
      acc_d = acc_new;
      if (s2_last_q) begin
        out_acc_d   = acc_new;
        out_data_d  = OUT_W'(sat);
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      ch_num_q    <= CH_W'(1);
      shift_q     <= '0;
      relu_q      <= 1'b0;
      for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_shift_q  <= '0;
      s1_relu_q   <= 1'b0;
      sum_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_shift_q  <= '0;
      s2_relu_q   <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_acc_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ch_num_q    <= ch_num_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      prod_q      <= prod_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_shift_q  <= s1_shift_d;
      s1_relu_q   <= s1_relu_d;
      sum_q       <= sum_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_shift_q  <= s2_shift_d;
      s2_relu_q   <= s2_relu_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_acc_q   <= out_acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_acc   = out_acc_q;

endmodule

// File: tb/tb_inner_dot_mac_pipe.sv
// Directed bench for inner_dot_mac_pipe: hand-computed sums, latency, stall, config latching, reset.
module tb_inner_dot_mac_pipe;
  localparam int TAPS = 9, DATA_W = 8, ACC_W = 32, CH_W = 8, OUT_W = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [CH_W-1:0]        cfg_ch_num;
  logic [4:0]             cfg_shift;
  logic                   cfg_relu;
  logic                   in_valid;
  logic                   in_ready;
  logic [TAPS*DATA_W-1:0] in_data;
  logic [TAPS*DATA_W-1:0] in_weight;
  logic                   out_valid;
  logic                   out_ready;
  logic [OUT_W-1:0]       out_data;
  logic [ACC_W-1:0]       out_acc;

  int n_checks = 0;
  int n_pass   = 0;
  longint got_acc_q[$];
  longint got_data_q[$];

  inner_dot_mac_pipe #(.TAPS(TAPS), .DATA_W(DATA_W), .ACC_W(ACC_W), .CH_W(CH_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .cfg_ch_num(cfg_ch_num), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_acc(out_acc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_acc_q.push_back(longint'($signed(out_acc)));
      got_data_q.push_back(longint'($signed(out_data)));
      $display("out: acc=%0d data=%0d", $signed(out_acc), $signed(out_data));
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // element 0 = d0, elements 1..TAPS-1 = d_rest, all weights = w; returns at posedge+1 after acceptance
  task automatic send_beat(input int d0, input int d_rest, input int w);
    bit done = 0;
    for (int i = 0; i < TAPS; i++) begin
      in_data[i*DATA_W +: DATA_W]   = (i == 0) ? DATA_W'(d0) : DATA_W'(d_rest);
      in_weight[i*DATA_W +: DATA_W] = DATA_W'(w);
    end
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    $display("beat: d0=%0d rest=%0d w=%0d accepted=%0d", d0, d_rest, w, done);
    if (!done) check("in_ready_timeout", 0, 1);
  endtask

  task automatic expect_out(input string tag, input longint exp_acc, input longint exp_data);
    int c = 0;
    while (got_acc_q.size() == 0 && c < 60) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (got_acc_q.size() == 0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_acc"}, got_acc_q.pop_front(), exp_acc);
      check({tag, "_data"}, got_data_q.pop_front(), exp_data);
    end
  endtask

  task automatic set_cfg(input int ch, input int sh, input bit relu);
    cfg_ch_num = CH_W'(ch);
    cfg_shift  = 5'(sh);
    cfg_relu   = relu;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcount;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_weight = '0;
    set_cfg(1, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_out_acc", longint'(out_acc), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single beat, latency n+3
    set_cfg(1, 0, 0);
    send_beat(1, 1, 1);
    @(negedge clk); check("t1_lat_n1", longint'(out_valid), 0);
    @(negedge clk); check("t1_lat_n2", longint'(out_valid), 0);
    @(negedge clk); check("t1_lat_n3", longint'(out_valid), 1);
    @(posedge clk); #1;
    expect_out("t1", 9, 9);

    // 2: four beats of -128*-128, saturates
    set_cfg(4, 8, 0);
    repeat (4) send_beat(-128, -128, -128);
    expect_out("t2", 589824, 127);

    // 3: relu and round-half-up
    set_cfg(1, 0, 0); send_beat(-1, -1, 1); expect_out("t3_relu0", -9, -9);
    set_cfg(1, 0, 1); send_beat(-1, -1, 1); expect_out("t3_relu1", -9, 0);
    set_cfg(1, 1, 0); send_beat(-1, -1, 1); expect_out("t3_shift1", -9, -4);

    // 4: stream 1..10 with a 5-cycle downstream stall
    set_cfg(1, 0, 0);
    fork
      for (int k = 1; k <= 10; k++) send_beat(k, 0, 1);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("t4_stall_in_ready", longint'(in_ready), 0);
          check("t4_stall_out_valid", longint'(out_valid), 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int k = 1; k <= 10; k++) expect_out($sformatf("t4_k%0d", k), k, k);

    // 5: mid-group ch_num change is ignored
    set_cfg(3, 0, 0);
    send_beat(1, 0, 1);
    cfg_ch_num = 8'd1;
    send_beat(2, 0, 1);
    send_beat(3, 0, 1);
    expect_out("t5_grp3", 6, 6);
    send_beat(7, 0, 1);
    expect_out("t5_grp1", 7, 7);

    // 6: reset mid-group discards partial sum
    set_cfg(4, 0, 0);
    send_beat(10, 0, 1);
    send_beat(10, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_in_ready", longint'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    vcount = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) vcount++;
    end
    @(posedge clk); #1;
    check("t6_no_out_valid", vcount, 0);
    set_cfg(1, 0, 0);
    send_beat(5, 0, 1);
    expect_out("t6_after_rst", 5, 5);

    repeat (10) @(posedge clk);
    check("no_extra_outputs", got_acc_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
